// File: rtl/pdec_updt_llr_if.sv
// Bundle between the read controller, the LLR update stage, the inner LLR SRAM,
// the bit-decision logic and the top controller.
interface pdec_updt_llr_if #(
  parameter int WID_INN      = 10,
  parameter int WID_LLR_ADDR = 6,
  parameter int NUM_PATH     = 8
);
  logic                              cur_fg;
  logic [3:0]                        cur_stage;
  logic [NUM_PATH-1:0]               rdc2ulr_llr_st;
  logic [NUM_PATH-1:0]               rdc2ulr_llr_en;
  logic [WID_INN*8*NUM_PATH-1:0]     rdc2ulr_llr_data;
  logic [4*NUM_PATH-1:0]             rdc2ulr_us_data;
  logic [3*NUM_PATH-1:0]             uph2ulr_wr_bank;
  logic [NUM_PATH-1:0]               ulr2sram_llr_wen;
  logic [WID_LLR_ADDR*NUM_PATH-1:0]  ulr2sram_llr_waddr;
  logic [WID_INN*8*NUM_PATH-1:0]     ulr2sram_llr_wdata;
  logic [8*NUM_PATH-1:0]             ulr2sram_llr_wmask;
  logic [NUM_PATH-1:0]               ulr2dec_llr_vld;
  logic [WID_INN*NUM_PATH-1:0]       ulr2dec_llr;
  logic                              ulr2ctrl_updt_done;
  logic                              pdec_clk_en2;

  modport master (
    output cur_fg, cur_stage, rdc2ulr_llr_st, rdc2ulr_llr_en, rdc2ulr_llr_data,
           rdc2ulr_us_data, uph2ulr_wr_bank,
    input  ulr2sram_llr_wen, ulr2sram_llr_waddr, ulr2sram_llr_wdata, ulr2sram_llr_wmask,
           ulr2dec_llr_vld, ulr2dec_llr, ulr2ctrl_updt_done, pdec_clk_en2
  );

  modport slave (
    input  cur_fg, cur_stage, rdc2ulr_llr_st, rdc2ulr_llr_en, rdc2ulr_llr_data,
           rdc2ulr_us_data, uph2ulr_wr_bank,
    output ulr2sram_llr_wen, ulr2sram_llr_waddr, ulr2sram_llr_wdata, ulr2sram_llr_wmask,
           ulr2dec_llr_vld, ulr2dec_llr, ulr2ctrl_updt_done, pdec_clk_en2
  );
endinterface

// File: rtl/pdec_updt_llr.sv
// Polar-decoder LLR update: F/G kernel on 4 pairs per beat, packs results into
// 8-lane words and routes each path's word to its destination SRAM bank.
//
// state | meaning
// IDLE  | waiting for a start pulse
// BUSY  | beats streaming in
// DRAIN | last write leaving the pipe, done pulse issued on exit
module pdec_updt_llr #(
  parameter int WID_INN      = 10,
  parameter int WID_LLR_ADDR = 6,
  parameter int NUM_PATH     = 8
) (
  input logic          clk,
  input logic          rst_n,
  pdec_updt_llr_if.slave bus
);
  localparam int W  = WID_INN;
  localparam int A  = WID_LLR_ADDR;
  localparam int NP = NUM_PATH;

  localparam logic signed [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] NMAXV = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   MAXE  = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   NMAXE = {2'b11, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic   done_d, done_q;

  logic [NP-1:0][7:0][W-1:0] llr_in;
  logic [NP-1:0][3:0]        us_in;
  logic [NP-1:0][2:0]        bank_in;
  logic                      any_st, any_en;

  logic [3:0]                stage_q;
  logic                      fg_q;
  logic [NP-1:0][2:0]        bank_q;
  logic                      parity_q;
  logic [A-1:0]              addr_q, base_addr, wr_addr;

  logic [NP-1:0][3:0][W-1:0] kres_d, kres_q, hold_q;
  logic [NP-1:0]             kvld_q;
  logic                      kodd_q;

  logic [NP-1:0]             pw_en;
  logic [NP-1:0][7:0][W-1:0] pw_data;
  logic [NP-1:0][7:0]        pw_mask;

  logic [NP-1:0]             wen_d, wen_q;
  logic [NP-1:0][A-1:0]      waddr_d, waddr_q;
  logic [NP-1:0][7:0][W-1:0] wdata_d, wdata_q;
  logic [NP-1:0][7:0]        wmask_d, wmask_q;
  logic [NP-1:0]             dvld_d, dvld_q;
  logic [NP-1:0][W-1:0]      dllr_d, dllr_q;

  assign llr_in  = bus.rdc2ulr_llr_data;
  assign us_in   = bus.rdc2ulr_us_data;
  assign bank_in = bus.uph2ulr_wr_bank;
  assign any_st  = |bus.rdc2ulr_llr_st;
  assign any_en  = |bus.rdc2ulr_llr_en;

  // The most negative code has no positive twin; fold it onto -MAX.
  function automatic logic signed [W-1:0] sat_in(input logic signed [W-1:0] x);
    return (x == MINV) ? NMAXV : x;
  endfunction

  function automatic logic [W-1:0] f_kern(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
    logic signed [W-1:0] ac, bc, ma, mb, m;
    ac = sat_in(a);
    bc = sat_in(b);
    ma = ac[W-1] ? -ac : ac;
    mb = bc[W-1] ? -bc : bc;
    m  = (ma < mb) ? ma : mb;
    return (ac[W-1] ^ bc[W-1]) ? -m : m;
  endfunction

  function automatic logic [W-1:0] g_kern(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b,
                                          input logic u);
    logic signed [W-1:0] ac, bc;
    logic signed [W:0]   s;
    ac = sat_in(a);
    bc = sat_in(b);
    s  = u ? ($signed({bc[W-1], bc}) - $signed({ac[W-1], ac}))
           : ($signed({bc[W-1], bc}) + $signed({ac[W-1], ac}));
    if (s > MAXE)       return MAXV;
    else if (s < NMAXE) return NMAXV;
    else                return s[W-1:0];
  endfunction

  always_comb begin
    kres_d = '0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 4; k++) begin
        kres_d[p][k] = fg_q ? f_kern(llr_in[p][k], llr_in[p][k+4])
                            : g_kern(llr_in[p][k], llr_in[p][k+4], us_in[p][k]);
      end
    end
  end

  assign base_addr = (bus.cur_stage >= 4'd3) ?
                     ({{(A-1){1'b0}}, 1'b1} << (bus.cur_stage - 4'd3)) : '0;
  assign wr_addr   = (stage_q >= 4'd3) ? addr_q : '0;

  always_comb begin
    pw_en   = '0;
    pw_data = '0;
    pw_mask = '0;
    dvld_d  = '0;
    dllr_d  = '0;
    for (int p = 0; p < NP; p++) begin
      if (kvld_q[p]) begin
        if (stage_q >= 4'd3) begin
          if (kodd_q) begin
            pw_en[p]   = 1'b1;
            pw_mask[p] = 8'hFF;
            for (int k = 0; k < 4; k++) begin
              pw_data[p][k]   = hold_q[p][k];
              pw_data[p][k+4] = kres_q[p][k];
            end
          end
        end else if (stage_q == 4'd2) begin
          pw_en[p]   = 1'b1;
          pw_mask[p] = 8'hF0;
          for (int k = 0; k < 4; k++) pw_data[p][k+4] = kres_q[p][k];
        end else if (stage_q == 4'd1) begin
          pw_en[p]      = 1'b1;
          pw_mask[p]    = 8'h0C;
          pw_data[p][2] = kres_q[p][0];
          pw_data[p][3] = kres_q[p][1];
        end else begin
          pw_en[p]      = 1'b1;
          pw_mask[p]    = 8'h02;
          pw_data[p][1] = kres_q[p][0];
          dvld_d[p]     = 1'b1;
          dllr_d[p]     = kres_q[p][0];
        end
      end
    end
  end

  // Scan from the highest path down so the lowest-index path claims a shared bank.
  always_comb begin
    wen_d   = '0;
    waddr_d = '0;
    wdata_d = '0;
    wmask_d = '0;
    for (int b = 0; b < NP; b++) begin
      for (int p = NP-1; p >= 0; p--) begin
        if (pw_en[p] && (bank_q[p] == 3'(b))) begin
          wen_d[b]   = 1'b1;
          waddr_d[b] = wr_addr;
          wdata_d[b] = pw_data[p];
          wmask_d[b] = pw_mask[p];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (any_st) state_d = S_BUSY;
      S_BUSY:  if (!any_en && !any_st) state_d = S_DRAIN;
      S_DRAIN: begin
        done_d  = 1'b1;
        state_d = any_st ? S_BUSY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      stage_q  <= '0;
      fg_q     <= 1'b0;
      bank_q   <= '0;
      parity_q <= 1'b0;
      addr_q   <= '0;
      kres_q   <= '0;
      kvld_q   <= '0;
      kodd_q   <= 1'b0;
      hold_q   <= '0;
      wen_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      dvld_q   <= '0;
      dllr_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      kres_q  <= kres_d;
      kvld_q  <= bus.rdc2ulr_llr_en;
      kodd_q  <= parity_q;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      dvld_q  <= dvld_d;
      dllr_q  <= dllr_d;
      if (any_st) begin
        stage_q  <= bus.cur_stage;
        fg_q     <= bus.cur_fg;
        bank_q   <= bank_in;
        parity_q <= 1'b0;
        addr_q   <= base_addr;
        hold_q   <= '0;
      end else begin
        if (any_en) parity_q <= ~parity_q;
        if ((|kvld_q) && kodd_q && (stage_q >= 4'd3)) addr_q <= addr_q + 1'b1;
        for (int p = 0; p < NP; p++) begin
          if (kvld_q[p] && !kodd_q) hold_q[p] <= kres_q[p];
        end
      end
    end
  end

  assign bus.ulr2sram_llr_wen   = wen_q;
  assign bus.ulr2sram_llr_waddr = waddr_q;
  assign bus.ulr2sram_llr_wdata = wdata_q;
  assign bus.ulr2sram_llr_wmask = wmask_q;
  assign bus.ulr2dec_llr_vld    = dvld_q;
  assign bus.ulr2dec_llr        = dllr_q;
  assign bus.ulr2ctrl_updt_done = done_q;
  assign bus.pdec_clk_en2       = any_st | any_en | (state_q != S_IDLE);
endmodule

// File: tb/tb_pdec_updt_llr.sv
// Directed bench for pdec_updt_llr: hand-computed F/G results, packing per stage,
// bank arbitration, saturation and mid-update reset.
module tb_pdec_updt_llr;
  localparam int W  = 10;
  localparam int A  = 6;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;

  pdec_updt_llr_if #(.WID_INN(W), .WID_LLR_ADDR(A), .NUM_PATH(NP)) bus ();

  pdec_updt_llr #(.WID_INN(W), .WID_LLR_ADDR(A), .NUM_PATH(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int b, input int l, input int exp);
    logic [W-1:0] o, e;
    o = bus.ulr2sram_llr_wdata[(b*8+l)*W +: W];
    e = exp[W-1:0];
    chk(tag, 64'(o), 64'(e));
  endtask

  task automatic chk_word(input string tag, input int b, input int ad, input int mk,
                          input int e0, input int e1, input int e2, input int e3,
                          input int e4, input int e5, input int e6, input int e7);
    int          ev [8];
    logic [7:0]  m;
    ev = '{e0, e1, e2, e3, e4, e5, e6, e7};
    m  = mk[7:0];
    chk({tag, "_addr"}, 64'(bus.ulr2sram_llr_waddr[b*A +: A]), 64'(ad));
    chk({tag, "_mask"}, 64'(bus.ulr2sram_llr_wmask[b*8 +: 8]), 64'(m));
    for (int l = 0; l < 8; l++) begin
      if (m[l]) chk_lane($sformatf("%s_lane%0d", tag, l), b, l, ev[l]);
    end
  endtask

  task automatic set_beat(input int p, input int x0, input int x1, input int x2, input int x3,
                          input int x4, input int x5, input int x6, input int x7);
    int xs [8];
    xs = '{x0, x1, x2, x3, x4, x5, x6, x7};
    for (int i = 0; i < 8; i++) bus.rdc2ulr_llr_data[(p*8+i)*W +: W] = W'(xs[i]);
  endtask

  task automatic set_us(input int p, input logic [3:0] u);
    bus.rdc2ulr_us_data[p*4 +: 4] = u;
  endtask

  task automatic set_bank(input int p, input int b);
    bus.uph2ulr_wr_bank[p*3 +: 3] = 3'(b);
  endtask

  task automatic clr();
    bus.cur_fg           = 1'b0;
    bus.cur_stage        = '0;
    bus.rdc2ulr_llr_st   = '0;
    bus.rdc2ulr_llr_en   = '0;
    bus.rdc2ulr_llr_data = '0;
    bus.rdc2ulr_us_data  = '0;
    bus.uph2ulr_wr_bank  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"},   64'(bus.ulr2sram_llr_wen), 64'd0);
    chk({tag, "_waddr"}, 64'(bus.ulr2sram_llr_waddr), 64'd0);
    chk({tag, "_wmask"}, bus.ulr2sram_llr_wmask, 64'd0);
    chk({tag, "_wdata"}, 64'(|bus.ulr2sram_llr_wdata), 64'd0);
    chk({tag, "_dvld"},  64'(bus.ulr2dec_llr_vld), 64'd0);
    chk({tag, "_dllr"},  64'(bus.ulr2dec_llr), 64'd0);
    chk({tag, "_done"},  64'(bus.ulr2ctrl_updt_done), 64'd0);
    chk({tag, "_clken"}, 64'(bus.pdec_clk_en2), 64'd0);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // F, stage 3, path 0 -> bank 2, two identical beats
    bus.cur_fg = 1'b1; bus.cur_stage = 4'd3; set_bank(0, 2);
    bus.rdc2ulr_llr_st = 8'h01;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h01;
    set_beat(0, 5, -3, 7, 0, -8, -9, 2, -1);
    tick();
    tick();
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("s3_wen", 64'(bus.ulr2sram_llr_wen), 64'h04);
    chk_word("s3", 2, 1, 8'hFF, -5, 3, 2, 0, -5, 3, 2, 0);
    chk("s3_done_early", 64'(bus.ulr2ctrl_updt_done), 64'd0);
    chk("s3_clken_drain", 64'(bus.pdec_clk_en2), 64'd1);
    tick();
    chk("s3_done", 64'(bus.ulr2ctrl_updt_done), 64'd1);
    chk("s3_wen_after", 64'(bus.ulr2sram_llr_wen), 64'd0);
    tick();
    chk("s3_done_clear", 64'(bus.ulr2ctrl_updt_done), 64'd0);
    chk("s3_clken_idle", 64'(bus.pdec_clk_en2), 64'd0);

    // G, stage 2, path 2 -> bank 6; u0..u3 = 0,1,1,0
    clr();
    bus.cur_fg = 1'b0; bus.cur_stage = 4'd2; set_bank(2, 6); set_us(2, 4'b0110);
    set_beat(2, 100, 100, 100, -300, 511, 511, 511, -400);
    bus.rdc2ulr_llr_st = 8'h04;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h04;
    tick();
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("s2g_wen", 64'(bus.ulr2sram_llr_wen), 64'h40);
    chk_word("s2g", 6, 0, 8'hF0, 0, 0, 0, 0, 511, 411, 411, -511);
    tick();
    chk("s2g_done", 64'(bus.ulr2ctrl_updt_done), 64'd1);
    tick();

    // F, stage 0, path 4 -> bank 1: a=-7, b=-4 gives +4
    clr();
    bus.cur_fg = 1'b1; bus.cur_stage = 4'd0; set_bank(4, 1);
    set_beat(4, -7, 0, 0, 0, -4, 0, 0, 0);
    bus.rdc2ulr_llr_st = 8'h10;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h10;
    tick();
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("s0_dvld", 64'(bus.ulr2dec_llr_vld), 64'h10);
    chk("s0_dllr", 64'(bus.ulr2dec_llr[4*W +: W]), 64'd4);
    chk("s0_wen", 64'(bus.ulr2sram_llr_wen), 64'h02);
    chk_word("s0", 1, 0, 8'h02, 0, 4, 0, 0, 0, 0, 0, 0);
    tick();
    chk("s0_dvld_pulse", 64'(bus.ulr2dec_llr_vld), 64'd0);
    chk("s0_done", 64'(bus.ulr2ctrl_updt_done), 64'd1);
    tick();

    // F, stage 1, paths 1 and 3 both -> bank 5; path 1 wins
    clr();
    bus.cur_fg = 1'b1; bus.cur_stage = 4'd1; set_bank(1, 5); set_bank(3, 5);
    set_beat(1, 10, -30, 0, 0, -20, -40, 0, 0);
    set_beat(3, 1, 2, 0, 0, 1, 2, 0, 0);
    bus.rdc2ulr_llr_st = 8'h0A;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h0A;
    tick();
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("coll_wen", 64'(bus.ulr2sram_llr_wen), 64'h20);
    chk("coll_wmask_all", bus.ulr2sram_llr_wmask, 64'h0000_0C00_0000_0000);
    chk_word("coll", 5, 0, 8'h0C, 0, 0, -10, 30, 0, 0, 0, 0);
    chk("coll_dvld", 64'(bus.ulr2dec_llr_vld), 64'd0);
    tick();
    chk("coll_done", 64'(bus.ulr2ctrl_updt_done), 64'd1);
    tick();

    // F with -512 inputs, stage 2, path 0 -> bank 3
    clr();
    bus.cur_fg = 1'b1; bus.cur_stage = 4'd2; set_bank(0, 3);
    set_beat(0, -512, -512, -512, 5, -512, 511, 3, -512);
    bus.rdc2ulr_llr_st = 8'h01;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h01;
    tick();
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("min_wen", 64'(bus.ulr2sram_llr_wen), 64'h08);
    chk_word("min", 3, 0, 8'hF0, 0, 0, 0, 0, 511, -511, -3, -5);
    tick();
    tick();

    // G, stage 4, path 0 -> bank 7, two words back to back from base address 2
    clr();
    bus.cur_fg = 1'b0; bus.cur_stage = 4'd4; set_bank(0, 7);
    bus.rdc2ulr_llr_st = 8'h01;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h01;
    set_beat(0, 1, 2, 3, 4, 10, 20, 30, 40); set_us(0, 4'b0000);
    tick();
    set_beat(0, 1, 1, 1, 1, -5, -5, -5, -5); set_us(0, 4'b1111);
    tick();
    set_beat(0, 0, 0, 0, 0, 7, 8, 9, 10); set_us(0, 4'b0000);
    tick();
    chk("s4_w1_wen", 64'(bus.ulr2sram_llr_wen), 64'h80);
    chk_word("s4_w1", 7, 2, 8'hFF, 11, 22, 33, 44, -6, -6, -6, -6);
    set_beat(0, 2, 2, 2, 2, 2, 2, 2, 2); set_us(0, 4'b1111);
    tick();
    chk("s4_even_nowrite", 64'(bus.ulr2sram_llr_wen), 64'd0);
    bus.rdc2ulr_llr_en = '0;
    tick();
    chk("s4_w2_wen", 64'(bus.ulr2sram_llr_wen), 64'h80);
    chk_word("s4_w2", 7, 3, 8'hFF, 7, 8, 9, 10, 0, 0, 0, 0);
    tick();
    chk("s4_done", 64'(bus.ulr2ctrl_updt_done), 64'd1);
    tick();

    // Reset between the even and odd beat of stage 4
    clr();
    bus.cur_fg = 1'b1; bus.cur_stage = 4'd4; set_bank(0, 0);
    bus.rdc2ulr_llr_st = 8'h01;
    tick();
    bus.rdc2ulr_llr_st = '0;
    bus.rdc2ulr_llr_en = 8'h01;
    set_beat(0, 9, 9, 9, 9, 9, 9, 9, 9);
    tick();
    bus.rdc2ulr_llr_en = '0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_wen_c%0d", i), 64'(bus.ulr2sram_llr_wen), 64'd0);
      chk($sformatf("midrst_done_c%0d", i), 64'(bus.ulr2ctrl_updt_done), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
